// File: rtl/nbit_demorgan_sweep_checker_if.sv
// Control/status bundle for the De Morgan sweep checker.
// The master side issues start/config; the slave side (checker) reports progress.
interface nbit_demorgan_sweep_checker_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             mode;
  logic             inject_en;
  logic [N-1:0]     inject_vec;
  logic [N-1:0]     vec;
  logic             lhs;
  logic             rhs;
  logic             valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, mode, inject_en, inject_vec,
    input  vec, lhs, rhs, valid, busy, done, pass, err_cnt
  );

  modport slave (
    input  start, mode, inject_en, inject_vec,
    output vec, lhs, rhs, valid, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/nbit_demorgan_sweep_checker.sv
// Sweeps all 2^N vectors, evaluates both sides of a De Morgan identity in a
// registered pipeline and counts (saturating) mismatches between them.
module nbit_demorgan_sweep_checker #(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter bit INJECT_ALL = 1'b0  // debug: injection hits every vector
) (
  input  logic                           clk,
  input  logic                           rst,
  nbit_demorgan_sweep_checker_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic         mode;
    logic         inject_en;
    logic [N-1:0] inject_vec;
  } cfg_t;

  localparam logic [N-1:0]     VEC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  cfg_t             cfg_q;
  logic [N-1:0]     vec;
  logic             lhs, rhs, valid, busy, done, pass;
  logic [CNT_W-1:0] err_cnt, err_nxt;
  logic             lhs_c, rhs_c, inj_hit;

  always_comb begin
    lhs_c   = cfg_q.mode ? ~(|vec) : ~(&vec);
    rhs_c   = cfg_q.mode ? &(~vec) : |(~vec);
    inj_hit = cfg_q.inject_en && (INJECT_ALL || (vec == cfg_q.inject_vec));
    err_nxt = err_cnt;
    if (valid && (lhs != rhs) && (err_cnt != CNT_MAX))
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cfg_q   <= '0;
      vec     <= '0;
      lhs     <= 1'b0;
      rhs     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_cnt <= err_nxt;
      valid   <= (state == RUN);
      if (state == RUN) begin
        lhs <= lhs_c;
        rhs <= rhs_c ^ inj_hit;
      end
      case (state)
        IDLE, DONE: if (bus.start) begin
          state   <= RUN;
          cfg_q   <= '{mode: bus.mode, inject_en: bus.inject_en, inject_vec: bus.inject_vec};
          vec     <= '0;
          err_cnt <= '0;
          done    <= 1'b0;
          pass    <= 1'b0;
          busy    <= 1'b1;
        end
        RUN: begin
          if (vec == VEC_MAX) state <= DRAIN;
          else                vec   <= vec + 1'b1;
        end
        // Last compare lands on this edge, so judge pass on the updated count.
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
          pass  <= (err_nxt == '0);
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vec     = vec;
  assign bus.lhs     = lhs;
  assign bus.rhs     = rhs;
  assign bus.valid   = valid;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_nbit_demorgan_sweep_checker.sv
// Scoreboard bench: stimulus pushes expected lhs/rhs and end-of-sweep results,
// negedge monitors pop and compare on valid pulses and on done rising.
module tb_nbit_demorgan_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nbit_demorgan_sweep_checker_if #(.N(4), .CNT_W(8)) ia ();
  nbit_demorgan_sweep_checker_if #(.N(2), .CNT_W(8)) ib ();
  nbit_demorgan_sweep_checker_if #(.N(4), .CNT_W(2)) ic ();

  nbit_demorgan_sweep_checker #(.N(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  nbit_demorgan_sweep_checker #(.N(2), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  nbit_demorgan_sweep_checker #(.N(4), .CNT_W(2), .INJECT_ALL(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct { logic lhs; logic rhs; } exp_t;
  typedef struct { int err; logic pass; int pulses; } res_t;

  exp_t qa[$], qb[$];
  res_t da[$], db[$], dc[$];
  int   errors = 0, checks = 0;
  int   cnt_a = 0, cnt_b = 0, cnt_c = 0;
  logic done_a_q = 1'b0, done_b_q = 1'b0, done_c_q = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none at %0t", nm, $time);
  endtask

  // Hand rule: type 1 is 0 only at all-ones, type 2 is 1 only at zero.
  task automatic push_a(input logic m, input logic ie, input int iv);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.lhs = m ? (k == 0) : (k != 15);
      e.rhs = e.lhs ^ (ie && (k == iv));
      qa.push_back(e);
    end
    da.push_back('{ie ? 1 : 0, !ie, 16});
  endtask

  task automatic push_b(input logic m);
    logic [3:0] tbl;
    exp_t e;
    tbl = m ? 4'b0001 : 4'b0111;
    for (int k = 0; k < 4; k++) begin
      e.lhs = tbl[k];
      e.rhs = tbl[k];
      qb.push_back(e);
    end
    db.push_back('{0, 1'b1, 4});
  endtask

  task automatic go(input int d, input logic m, input logic ie, input logic [3:0] iv);
    @(posedge clk); #1;
    case (d)
      0: begin ia.mode = m; ia.inject_en = ie; ia.inject_vec = iv;      ia.start = 1'b1; cnt_a = 0; end
      1: begin ib.mode = m; ib.inject_en = ie; ib.inject_vec = iv[1:0]; ib.start = 1'b1; cnt_b = 0; end
      default: begin ic.mode = m; ic.inject_en = ie; ic.inject_vec = iv; ic.start = 1'b1; cnt_c = 0; end
    endcase
    @(posedge clk); #1;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
  endtask

  // Called in cycle t+1; done must first appear in cycle t+pre+2.
  task automatic run(input int d, input int pre, input string nm);
    logic dn, bz;
    repeat (pre) @(posedge clk);
    #1;
    dn = (d == 0) ? ia.done : (d == 1) ? ib.done : ic.done;
    bz = (d == 0) ? ia.busy : (d == 1) ? ib.busy : ic.busy;
    chk({nm, "_done_early"}, dn, 0);
    chk({nm, "_busy_run"}, bz, 1);
    @(posedge clk); #1;
    dn = (d == 0) ? ia.done : (d == 1) ? ib.done : ic.done;
    bz = (d == 0) ? ia.busy : (d == 1) ? ib.busy : ic.busy;
    chk({nm, "_done_set"}, dn, 1);
    chk({nm, "_busy_clr"}, bz, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    res_t r;
    if (ia.valid) begin
      cnt_a++;
      if (qa.size() == 0) miss("a_extra_valid");
      else begin
        e = qa.pop_front();
        chk("a_lhs", ia.lhs, e.lhs);
        chk("a_rhs", ia.rhs, e.rhs);
      end
    end
    if (ib.valid) begin
      cnt_b++;
      if (qb.size() == 0) miss("b_extra_valid");
      else begin
        e = qb.pop_front();
        chk("b_lhs", ib.lhs, e.lhs);
        chk("b_rhs", ib.rhs, e.rhs);
      end
    end
    if (ic.valid) cnt_c++;
    if (ia.done && !done_a_q) begin
      if (da.size() == 0) miss("a_unexp_done");
      else begin
        r = da.pop_front();
        chk("a_err_cnt", ia.err_cnt, r.err);
        chk("a_pass", ia.pass, r.pass);
        chk("a_pulses", cnt_a, r.pulses);
      end
    end
    if (ib.done && !done_b_q) begin
      if (db.size() == 0) miss("b_unexp_done");
      else begin
        r = db.pop_front();
        chk("b_err_cnt", ib.err_cnt, r.err);
        chk("b_pass", ib.pass, r.pass);
        chk("b_pulses", cnt_b, r.pulses);
      end
    end
    if (ic.done && !done_c_q) begin
      if (dc.size() == 0) miss("c_unexp_done");
      else begin
        r = dc.pop_front();
        chk("c_err_cnt", ic.err_cnt, r.err);
        chk("c_pass", ic.pass, r.pass);
        chk("c_pulses", cnt_c, r.pulses);
      end
    end
    done_a_q = ia.done;
    done_b_q = ib.done;
    done_c_q = ic.done;
  end

  initial begin
    ia.start = 0; ia.mode = 0; ia.inject_en = 0; ia.inject_vec = '0;
    ib.start = 0; ib.mode = 0; ib.inject_en = 0; ib.inject_vec = '0;
    ic.start = 0; ic.mode = 0; ic.inject_en = 0; ic.inject_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_reset_outs", {ia.vec, ia.lhs, ia.rhs, ia.valid, ia.busy, ia.done, ia.pass, ia.err_cnt}, 0);
    chk("b_reset_outs", {ib.vec, ib.lhs, ib.rhs, ib.valid, ib.busy, ib.done, ib.pass, ib.err_cnt}, 0);
    chk("c_reset_outs", {ic.vec, ic.lhs, ic.rhs, ic.valid, ic.busy, ic.done, ic.pass, ic.err_cnt}, 0);
    rst = 1'b0;

    // Clean type-1 sweep.
    push_a(0, 0, 0);
    go(0, 0, 0, 0);
    chk("t1_busy_start", ia.busy, 1);
    chk("t1_vec_start", ia.vec, 0);
    run(0, 16, "t1");

    // Type-2 with a single injected fault at vec 5.
    push_a(1, 1, 5);
    go(0, 1, 1, 5);
    run(0, 16, "t2");

    // Restart from DONE, then a mid-sweep start with other settings is ignored.
    push_a(0, 0, 0);
    go(0, 0, 0, 0);
    chk("t5_done_drop", ia.done, 0);
    chk("t5_err_clear", ia.err_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    ia.start = 1'b1; ia.mode = 1'b1; ia.inject_en = 1'b1; ia.inject_vec = 4'h0;
    @(posedge clk); #1;
    ia.start = 1'b0; ia.mode = 1'b0; ia.inject_en = 1'b0;
    run(0, 12, "t5");

    // Reset mid-sweep, then a full sweep with nominal timing.
    push_a(0, 0, 0);
    go(0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t4_reset_outs", {ia.vec, ia.lhs, ia.rhs, ia.valid, ia.busy, ia.done, ia.pass, ia.err_cnt}, 0);
    rst = 1'b0;
    qa.delete();
    da.delete();
    push_a(0, 0, 0);
    go(0, 0, 0, 0);
    run(0, 16, "t4");

    // N=2 truth tables for both identities.
    push_b(0);
    go(1, 0, 0, 0);
    run(1, 4, "t3m0");
    push_b(1);
    go(1, 1, 0, 0);
    run(1, 4, "t3m1");

    // Every vector injected into a 2-bit counter: must saturate at 3.
    dc.push_back('{3, 1'b0, 16});
    go(2, 0, 1, 0);
    run(2, 16, "t6");
    repeat (2) @(posedge clk);
    #1;
    chk("t6_err_hold", ic.err_cnt, 3);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("done_q_drained", da.size() + db.size() + dc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
